// File: rtl/fetch_arbiter_pkg.sv
// rtl/fetch_arbiter_pkg.sv - shared constants and FSM encoding for the fetch arbiter
package fetch_arbiter_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RESUME = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_arbiter_ld_counter.sv
// rtl/fetch_arbiter_ld_counter.sv - saturating load word counter with sticky overflow
module ld_counter #(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            inc_i,
  output logic [ADDR_W:0] count_o,
  output logic            full_o,
  output logic            overflow_o
);

  localparam logic [ADDR_W:0] MAX_C = (ADDR_W+1)'(MAX_WORDS);

  logic [ADDR_W:0] cnt_q;
  logic            ovf_q;

  assign count_o    = cnt_q;
  assign full_o     = (cnt_q == MAX_C);
  assign overflow_o = ovf_q;

  // An increment at the limit is the dropped word: flag it, hold the count.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (inc_i) begin
      if (full_o) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_arbiter.sv
// rtl/fetch_arbiter.sv - shares the instruction ROM port between core fetch and program load
module fetch_arbiter
  import fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [WORD_W-1:0] fetch_addr,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_done,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] inst,
  output logic              inst_valid,
  output logic              core_stall,
  output logic              pc_restart,
  output logic              ld_overflow
);

  state_e          state_q;
  logic            inst_valid_q;
  logic [ADDR_W:0] word_cnt;
  logic            cnt_full;
  logic            load_entry;
  logic            accept;
  logic            unused_ok;

  assign load_entry = (state_q == ST_RUN) && load_start;
  assign accept     = (state_q == ST_LOAD) && ld_valid;

  ld_counter #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS)
  ) u_ld_counter (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (load_entry),
    .inc_i      (accept),
    .count_o    (word_cnt),
    .full_o     (cnt_full),
    .overflow_o (ld_overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      inst_valid_q <= 1'b0;
    end else begin
      inst_valid_q <= (state_q == ST_RUN) && fetch_req && !load_start;
      case (state_q)
        ST_RUN:    if (load_start) state_q <= ST_LOAD;
        ST_LOAD:   if (ld_done) state_q <= ST_RESUME;
        ST_RESUME: state_q <= ST_RUN;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

  // Write strobe is masked by rst so an aborted load cannot land one more word.
  always_comb begin
    mem_addr   = fetch_addr[ADDR_W+1:2];
    mem_we     = 1'b0;
    mem_wdata  = '0;
    core_stall = 1'b0;
    ld_ready   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        core_stall = 1'b1;
        ld_ready   = 1'b1;
        mem_addr   = word_cnt[ADDR_W-1:0];
        mem_wdata  = ld_data;
        mem_we     = ld_valid && !cnt_full && !rst;
      end
      ST_RESUME: core_stall = 1'b1;
      default: ;
    endcase
  end

  assign pc_restart = (state_q == ST_RESUME);
  assign inst_valid = inst_valid_q;
  assign inst       = inst_valid_q ? mem_rdata : '0;

  assign unused_ok = ^{fetch_addr[WORD_W-1:ADDR_W+2], fetch_addr[1:0], word_cnt[ADDR_W]};

endmodule

// File: doc/fetch_arbiter.md
FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width of the instruction ROM (16384 words).
REQ-002 Parameter MAX_WORDS, default 2**ADDR_W, load-count limit before overflow.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 fetch_req  in  1  core requests an instruction read this cycle.
REQ-006 fetch_addr  in  32  core byte address (PC); bits [ADDR_W+1:2] form the word address.
REQ-007 load_start  in  1  one-cycle pulse requesting program-load mode.
REQ-008 ld_valid  in  1  loader presents a word.
REQ-009 ld_data  in  32  loader word.
REQ-010 ld_done  in  1  loader signals end of image.
REQ-011 ld_ready  out  1  arbiter accepts ld_data this cycle.
REQ-012 mem_addr  out  ADDR_W  ROM word address.
REQ-013 mem_we  out  1  ROM write enable.
REQ-014 mem_wdata  out  32  ROM write data.
REQ-015 mem_rdata  in  32  ROM read data, valid one cycle after the address.
REQ-016 inst  out  32  instruction to core.
REQ-017 inst_valid  out  1  inst holds data for a read issued the previous cycle.
REQ-018 core_stall  out  1  core shall hold its PC.
REQ-019 pc_restart  out  1  one-cycle pulse; core reloads PC to 0.
REQ-020 ld_overflow  out  1  sticky; load exceeded MAX_WORDS.

Function
REQ-021 FSM states: RUN, LOAD, RESUME; encoding in the shared package.
REQ-022 RUN: mem_addr=fetch_addr[ADDR_W+1:2], mem_we=0, core_stall=0, ld_ready=0.
REQ-023 Read latency 1: fetch_req in RUN at cycle N -> inst=mem_rdata, inst_valid=1 at cycle N+1.
REQ-024 inst_valid is a registered flag; it is 0 in any cycle whose previous cycle was not a RUN fetch.
REQ-025 RUN + load_start -> LOAD next cycle; the same-cycle fetch is issued but its inst_valid is suppressed.
REQ-026 LOAD: core_stall=1, ld_ready=1, mem_we=ld_valid, mem_addr=word counter, mem_wdata=ld_data.
REQ-027 Word counter (ADDR_W+1 bits) clears on LOAD entry and increments on each ld_valid&&ld_ready.
REQ-028 A write with counter == MAX_WORDS is dropped (mem_we=0) and sets ld_overflow; counter saturates.
REQ-029 LOAD + ld_done -> RESUME; a same-cycle ld_valid word is written before exit.
REQ-030 load_start during LOAD or RESUME is ignored.
REQ-031 RESUME lasts exactly one cycle: pc_restart=1, core_stall=1, mem_we=0, then RUN.
REQ-032 ld_overflow clears only on rst or on the next LOAD entry.
REQ-033 fetch_req is ignored outside RUN.

Reset
REQ-034 rst -> state RUN, counter 0, inst=0, inst_valid=0, pc_restart=0, ld_overflow=0.
REQ-035 Reset during LOAD aborts the load: no further writes, next cycle RUN; ROM contents already written are retained.
REQ-036 Outputs derived combinationally from state take their RUN values in the cycle after rst.

Structure
REQ-037 Shared package holds the state enumeration, ADDR_W default and the 32-bit word width constant.
REQ-038 One sub-module, ld_counter, implements the saturating word counter and overflow flag.
REQ-039 The ROM instance stays outside this block; the block drives its single port only.

Verification
REQ-040 Fetch stream: fetch_addr 0x0,0x4,0x8 on three cycles with ROM preset 0x11,0x22,0x33 -> inst 0x11,0x22,0x33 with inst_valid on the following three cycles.
REQ-041 Load: load_start, then 4 ld_valid words 0xA0..0xA3, ld_done -> writes to addresses 0..3, one pc_restart pulse, then fetch of 0x0 returns 0xA0.
REQ-042 ld_done together with ld_valid 0xBB as fifth word -> 0xBB written at address 4, then RESUME.
REQ-043 Overflow: MAX_WORDS=4, push 6 words -> only addresses 0..3 written, ld_overflow=1 until next load_start.
REQ-044 rst asserted after 2 loaded words -> next cycle RUN, inst_valid=0, no pc_restart, addresses 0..1 keep the new data.
REQ-045 load_start coinciding with fetch_req -> no inst_valid for that fetch; core_stall=1 next cycle.
